arch_reg_dump_engine: RTL and testbench
=======================================

// Module: arch_reg_dump_engine
// PURPOSE
//  Debug reader for in-core architectural state. On request, freezes commit, walks the
//  selected architectural registers, and resolves each through the rename map table
//  (arch->phys) and the PRF. Streams {areg, preg, value} beats on a valid/ready port
//  to the debug/trace sink. Sits beside rename_unit and PRF inside processor.
// PARAMETERS
//  ARCH_REGS  32  number of architectural registers walked (index width AREG_W=$clog2)
//  PREG_W     7   physical register tag width
//  XLEN       32  register data width
// PORTS
//  clk         in   1          clock
//  reset       in   1          synchronous, active-low reset
//  dump_start  in   1          pulse: begin dump (sampled only in IDLE)
//  dump_mask   in   ARCH_REGS  bit i=1 -> include areg i; latched at dump_start
//  dump_abort  in   1          terminate dump, return to IDLE
//  dump_busy   out  1          high in any state except IDLE
//  dump_done   out  1          1-cycle pulse on normal completion
//  freeze_req  out  1          request rename/commit stall
//  freeze_ack  in   1          core quiesced; map/PRF stable
//  map_raddr   out  AREG_W     map table read index (combinational read)
//  map_rdata   in   PREG_W     phys tag for map_raddr, same cycle
//  prf_raddr   out  PREG_W     PRF read tag
//  prf_rdata   in   XLEN       PRF data, valid one cycle after prf_raddr
//  out_valid   out  1          beat valid
//  out_ready   in   1          sink accepts beat
//  out_areg    out  AREG_W     architectural index
//  out_preg    out  PREG_W     phys tag
//  out_data    out  XLEN       register value
//  out_last    out  1          final selected register of dump
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE; all outputs 0; idx=0; latched mask=0.
//  States: IDLE, FREEZE, READ, WAIT, SEND, DONE.
//  IDLE: dump_start=1 -> latch mask, idx=first set bit, FREEZE. Else hold.
//  FREEZE: freeze_req=1 (held through DONE). freeze_ack=1 -> READ, or DONE if mask==0.
//  READ: map_raddr=idx; capture map_rdata into preg reg; prf_raddr=map_rdata -> WAIT.
//  WAIT: capture prf_rdata (x0: force data=0 regardless of PRF); load out regs -> SEND.
//  SEND: out_valid=1, outputs stable until out_ready. On out_valid&out_ready: if last
//   -> DONE, else idx=next set bit above idx -> READ.
//  out_last=1 iff idx is highest set bit of latched mask.
//  DONE: dump_done=1 one cycle, freeze_req=0 -> IDLE (freeze released same cycle as done).
//  Throughput: 3 cycles/beat with out_ready tied high; out_ready low stalls in SEND only.
//  dump_start while busy: ignored. dump_mask changes while busy: no effect.
//  dump_abort (any non-IDLE state): next cycle IDLE, freeze_req=0, out_valid=0,
//   no dump_done. Abort wins over simultaneous out_ready handshake (beat dropped).
//  freeze_ack deasserting after FREEZE: ignored; engine trusts freeze until release.
//  Reset mid-dump: immediate return to reset values; no partial done.
//  out_valid never depends combinationally on out_ready.
// TESTING
//  1. Preload areg i -> preg i+32, PRF[i+32]=0x1000+i; mask=all; ready=1 -> 32 beats
//     areg 0..31, beat0 data=0, beat31 data=0x101F with out_last=1, then dump_done.
//  2. Mask=0x00100402 (x1,x10,x20) -> exactly 3 beats in ascending order; last on x20;
//     x20 mapped to preg 5, PRF[5]=0xDEADBEEF -> out_data=0xDEADBEEF, out_preg=5.
//  3. freeze_ack held low 10 cycles -> no map/PRF reads, out_valid=0, freeze_req=1.
//  4. out_ready toggled 1/0 randomly on test 1 -> identical beat sequence, no beat lost
//     or duplicated, outputs stable while valid&!ready.
//  5. dump_abort during SEND of 4th beat -> IDLE next cycle, freeze_req=0, no dump_done;
//     fresh dump_start then completes normally. mask=0 -> done after ack, zero beats.
//  6. reset low mid-dump in WAIT -> all outputs 0 next cycle; dump_start ignored while
//     busy (second pulse mid-dump yields one dump_done total).

Source files
------------

// File: rtl/arch_reg_dump_if.sv
// Beat stream from the architectural register dump engine to the debug/trace sink.
// Each accepted beat carries one {areg, preg, value} triple.
interface arch_reg_dump_if #(
  parameter int ARCH_REGS = 32,
  parameter int PREG_W    = 7,
  parameter int XLEN      = 32
) ();
  localparam int AREG_W = $clog2(ARCH_REGS);

  logic              out_valid;
  logic              out_ready;
  logic [AREG_W-1:0] out_areg;
  logic [PREG_W-1:0] out_preg;
  logic [XLEN-1:0]   out_data;
  logic              out_last;

  modport master (
    output out_valid, out_areg, out_preg, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_areg, out_preg, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/arch_reg_dump_engine.sv
// Debug reader: freezes commit, walks the selected architectural registers through the
// rename map and PRF, and streams one {areg, preg, value} beat per selected register.
module arch_reg_dump_engine #(
  parameter int  ARCH_REGS = 32,
  parameter int  PREG_W    = 7,
  parameter int  XLEN      = 32,
  localparam int AREG_W    = $clog2(ARCH_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dump_start,
  input  logic [ARCH_REGS-1:0] dump_mask,
  input  logic                 dump_abort,
  output logic                 dump_busy,
  output logic                 dump_done,
  output logic                 freeze_req,
  input  logic                 freeze_ack,
  output logic [AREG_W-1:0]    map_raddr,
  input  logic [PREG_W-1:0]    map_rdata,
  output logic [PREG_W-1:0]    prf_raddr,
  input  logic [XLEN-1:0]      prf_rdata,
  arch_reg_dump_if.master      out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FREEZE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [ARCH_REGS-1:0] mask_q, mask_d;
  logic [AREG_W-1:0]    idx_q, idx_d;
  logic [PREG_W-1:0]    preg_q, preg_d;
  logic [AREG_W-1:0]    oareg_q, oareg_d;
  logic [PREG_W-1:0]    opreg_q, opreg_d;
  logic [XLEN-1:0]      odata_q, odata_d;
  logic                 olast_q, olast_d;

  // Lowest set bit of m at or above index 'from'; 0 when there is none.
  function automatic logic [AREG_W-1:0] first_set(input logic [ARCH_REGS-1:0] m,
                                                  input int from);
    first_set = '0;
    for (int i = ARCH_REGS - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) first_set = AREG_W'(i);
    end
  endfunction

  function automatic logic any_above(input logic [ARCH_REGS-1:0] m, input int from);
    any_above = 1'b0;
    for (int i = 0; i < ARCH_REGS; i++) begin
      if (m[i] && (i > from)) any_above = 1'b1;
    end
  endfunction

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    preg_d  = preg_q;
    oareg_d = oareg_q;
    opreg_d = opreg_q;
    odata_d = odata_q;
    olast_d = olast_q;

    unique case (state_q)
      S_IDLE: begin
        if (dump_start) begin
          mask_d  = dump_mask;
          idx_d   = first_set(dump_mask, 0);
          state_d = S_FREEZE;
        end
      end
      S_FREEZE: begin
        if (freeze_ack) state_d = (mask_q == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        preg_d  = map_rdata;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // x0 is hardwired zero, whatever its physical register holds.
        oareg_d = idx_q;
        opreg_d = preg_q;
        odata_d = (idx_q == '0) ? '0 : prf_rdata;
        olast_d = !any_above(mask_q, int'(idx_q));
        state_d = S_SEND;
      end
      S_SEND: begin
        if (out.out_ready) begin
          if (olast_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = first_set(mask_q, int'(idx_q) + 1);
            state_d = S_READ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort beats any in-flight handshake; the offered beat is dropped.
    if (dump_abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      oareg_q <= '0;
      opreg_q <= '0;
      odata_q <= '0;
      olast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      oareg_q <= oareg_d;
      opreg_q <= opreg_d;
      odata_q <= odata_d;
      olast_q <= olast_d;
    end
  end

  always_ff @(posedge clk) begin
    preg_q <= preg_d;
  end

  assign dump_busy  = (state_q != S_IDLE);
  assign dump_done  = (state_q == S_DONE);
  assign freeze_req = state_q inside {S_FREEZE, S_READ, S_WAIT, S_SEND};
  assign map_raddr  = (state_q == S_READ) ? idx_q : '0;
  assign prf_raddr  = (state_q == S_READ) ? map_rdata : '0;

  assign out.out_valid = (state_q == S_SEND);
  assign out.out_areg  = oareg_q;
  assign out.out_preg  = opreg_q;
  assign out.out_data  = odata_q;
  assign out.out_last  = olast_q;

endmodule

// File: tb/tb_arch_reg_dump_engine.sv
// Bench for arch_reg_dump_engine: table of dump scenarios checked against a reference
// beat list built from the mask, map table and PRF contents, plus a reset-mid-dump sequence.
module tb_arch_reg_dump_engine;
  localparam int AR = 32;
  localparam int PW = 7;
  localparam int XL = 32;
  localparam int NV = 12;

  typedef struct packed {
    logic [4:0]    areg;
    logic [PW-1:0] preg;
    logic [XL-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [AR-1:0] mask;
    bit            rnd_ready;
    bit            remap20;
    bit            rnd_map;
    int            ack_delay;
    int            abort_beat;
    int            dup_start;
    int            exp_beats;
    int            exp_done;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          dump_start = 1'b0;
  logic          dump_abort = 1'b0;
  logic          freeze_ack = 1'b0;
  logic [AR-1:0] dump_mask = '0;
  logic          dump_busy, dump_done, freeze_req;
  logic [4:0]    map_raddr;
  logic [PW-1:0] map_rdata;
  logic [PW-1:0] prf_raddr;
  logic [XL-1:0] prf_rdata;

  logic [PW-1:0] map_tbl [AR];
  logic [XL-1:0] prf_mem [128];

  int    checks = 0;
  int    failures = 0;
  int    beats_seen, done_seen, busy_cyc;
  bit    rand_ready = 1'b0;
  bit    stalled = 1'b0;
  bit    aborted, abort_now;
  beat_t held;
  beat_t exp_q[$];
  beat_t got_q[$];
  vec_t  vecs [NV];

  arch_reg_dump_if #(.ARCH_REGS(AR), .PREG_W(PW), .XLEN(XL)) ob ();

  arch_reg_dump_engine #(.ARCH_REGS(AR), .PREG_W(PW), .XLEN(XL)) dut (
    .clk        (clk),
    .reset      (reset),
    .dump_start (dump_start),
    .dump_mask  (dump_mask),
    .dump_abort (dump_abort),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done),
    .freeze_req (freeze_req),
    .freeze_ack (freeze_ack),
    .map_raddr  (map_raddr),
    .map_rdata  (map_rdata),
    .prf_raddr  (prf_raddr),
    .prf_rdata  (prf_rdata),
    .out        (ob)
  );

  always #5 clk = ~clk;

  assign map_rdata = map_tbl[map_raddr];
  always @(posedge clk) prf_rdata <= prf_mem[prf_raddr];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Expected beats: every selected register in ascending order, x0 reads as zero.
  task automatic build_model(input logic [AR-1:0] m);
    exp_q.delete();
    for (int i = 0; i < AR; i++) begin
      if (m[i]) exp_q.push_back('{areg: 5'(i), preg: map_tbl[i],
                                  data: (i == 0) ? 32'h0 : prf_mem[map_tbl[i]], last: 1'b0});
    end
    if (exp_q.size() > 0) exp_q[exp_q.size() - 1].last = 1'b1;
  endtask

  // One clock: observe the sink side at the falling edge, then step past the rising edge.
  task automatic tick();
    beat_t cur, e;
    @(negedge clk);
    cur = '{areg: ob.out_areg, preg: ob.out_preg, data: ob.out_data, last: ob.out_last};
    if (reset && ob.out_valid) begin
      if (stalled) chk("hold_stable", 64'(cur), 64'(held));
      if (ob.out_ready && !dump_abort) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat actual=%0h expected=none", cur);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 64'(cur), 64'(e));
        end
        got_q.push_back(cur);
        beats_seen++;
      end
      stalled = !ob.out_ready;
      held    = cur;
    end else begin
      stalled = 1'b0;
    end
    if (reset && dump_done) begin
      done_seen++;
      chk("done_freeze_released", 64'(freeze_req), 64'(0));
    end
    @(posedge clk);
    #1;
    ob.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  initial begin
    ob.out_ready = 1'b1;
    vecs[0] = '{mask: 32'hFFFF_FFFF, rnd_ready: 0, remap20: 0, rnd_map: 0, ack_delay: 0,
                abort_beat: -1, dup_start: -1, exp_beats: 32, exp_done: 1};
    vecs[1] = '{mask: 32'h0010_0402, rnd_ready: 0, remap20: 1, rnd_map: 0, ack_delay: 0,
                abort_beat: -1, dup_start: -1, exp_beats: 3, exp_done: 1};
    vecs[2] = '{mask: 32'hFFFF_FFFF, rnd_ready: 1, remap20: 0, rnd_map: 0, ack_delay: 0,
                abort_beat: -1, dup_start: -1, exp_beats: 32, exp_done: 1};
    vecs[3] = '{mask: 32'hFFFF_FFFF, rnd_ready: 0, remap20: 0, rnd_map: 0, ack_delay: 0,
                abort_beat: 3, dup_start: -1, exp_beats: 3, exp_done: 0};
    vecs[4] = '{mask: 32'hFFFF_FFFF, rnd_ready: 0, remap20: 0, rnd_map: 0, ack_delay: 0,
                abort_beat: -1, dup_start: -1, exp_beats: 32, exp_done: 1};
    vecs[5] = '{mask: 32'h0, rnd_ready: 0, remap20: 0, rnd_map: 0, ack_delay: 0,
                abort_beat: -1, dup_start: -1, exp_beats: 0, exp_done: 1};
    vecs[6] = '{mask: 32'h0010_0402, rnd_ready: 0, remap20: 0, rnd_map: 0, ack_delay: 10,
                abort_beat: -1, dup_start: -1, exp_beats: 3, exp_done: 1};
    vecs[7] = '{mask: 32'hFFFF_FFFF, rnd_ready: 0, remap20: 0, rnd_map: 0, ack_delay: 0,
                abort_beat: -1, dup_start: 20, exp_beats: 32, exp_done: 1};
    for (int r = 8; r < NV; r++) begin
      logic [AR-1:0] m;
      m = $urandom;
      vecs[r] = '{mask: m, rnd_ready: 1, remap20: 0, rnd_map: 1, ack_delay: 0,
                  abort_beat: -1, dup_start: -1, exp_beats: $countones(m), exp_done: 1};
    end

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 64'(dump_busy), 64'(0));
    chk("rst_done", 64'(dump_done), 64'(0));
    chk("rst_freeze", 64'(freeze_req), 64'(0));
    chk("rst_valid", 64'(ob.out_valid), 64'(0));
    chk("rst_beat", 64'({ob.out_areg, ob.out_preg, ob.out_data, ob.out_last}), 64'(0));
    chk("rst_raddr", 64'({map_raddr, prf_raddr}), 64'(0));
    reset = 1'b1;
    tick();

    for (int r = 0; r < NV; r++) begin
      for (int i = 0; i < 128; i++) prf_mem[i] = vecs[r].rnd_map ? $urandom : 32'h0;
      for (int i = 0; i < AR; i++) begin
        if (vecs[r].rnd_map) begin
          map_tbl[i] = 7'($urandom_range(0, 127));
        end else begin
          map_tbl[i]      = 7'(i + 32);
          prf_mem[i + 32] = 32'(32'h1000 + i);
        end
      end
      if (vecs[r].remap20) begin
        map_tbl[20] = 7'd5;
        prf_mem[5]  = 32'hDEAD_BEEF;
      end
      build_model(vecs[r].mask);
      got_q.delete();
      beats_seen = 0;
      done_seen  = 0;
      stalled    = 1'b0;
      rand_ready = vecs[r].rnd_ready;
      freeze_ack = (vecs[r].ack_delay == 0);
      dump_start = 1'b1;
      dump_mask  = vecs[r].mask;
      tick();
      dump_start = 1'b0;
      dump_mask  = $urandom;
      busy_cyc   = 0;
      aborted    = 1'b0;
      while (dump_busy && busy_cyc < 3000) begin
        if (busy_cyc < vecs[r].ack_delay) begin
          chk("frz_no_valid", 64'(ob.out_valid), 64'(0));
          chk("frz_req", 64'(freeze_req), 64'(1));
        end
        if (busy_cyc == vecs[r].ack_delay - 1) freeze_ack = 1'b1;
        dump_start = (busy_cyc == vecs[r].dup_start);
        if (dump_start) dump_mask = 32'h1;
        abort_now = (vecs[r].abort_beat >= 0) && !aborted &&
                    (beats_seen == vecs[r].abort_beat) && ob.out_valid;
        dump_abort = abort_now;
        tick();
        busy_cyc++;
        dump_abort = 1'b0;
        dump_start = 1'b0;
        if (abort_now) begin
          aborted = 1'b1;
          chk("abort_busy", 64'(dump_busy), 64'(0));
          chk("abort_freeze", 64'(freeze_req), 64'(0));
          chk("abort_valid", 64'(ob.out_valid), 64'(0));
        end
      end
      if (busy_cyc >= 3000) begin
        checks++;
        failures++;
        $display("FAIL timeout row=%0d actual=busy required=idle", r);
      end
      repeat (4) tick();
      chk("idle_after", 64'(dump_busy), 64'(0));
      chk("beat_count", 64'(beats_seen), 64'(vecs[r].exp_beats));
      chk("done_count", 64'(done_seen), 64'(vecs[r].exp_done));
      if (!vecs[r].rnd_ready && vecs[r].abort_beat < 0)
        chk("busy_cycles", 64'(busy_cyc),
            64'(((vecs[r].ack_delay > 0) ? vecs[r].ack_delay : 1) + 3 * vecs[r].exp_beats + 1));
      if (r == 0) begin
        if (got_q.size() == 32) begin
          chk("t1_beat0_data", 64'(got_q[0].data), 64'(0));
          chk("t1_beat31", 64'(got_q[31]), 64'({5'd31, 7'd63, 32'h101F, 1'b1}));
          chk("t1_beat30_last", 64'(got_q[30].last), 64'(0));
        end else begin
          chk("t1_size", 64'(got_q.size()), 64'(32));
        end
      end
      if (r == 1) begin
        if (got_q.size() == 3) begin
          chk("t2_areg0", 64'(got_q[0].areg), 64'(1));
          chk("t2_areg1", 64'(got_q[1].areg), 64'(10));
          chk("t2_x20", 64'(got_q[2]), 64'({5'd20, 7'd5, 32'hDEAD_BEEF, 1'b1}));
        end else begin
          chk("t2_size", 64'(got_q.size()), 64'(3));
        end
      end
    end

    // Reset pulled low while the first beat is in WAIT
    exp_q.delete();
    rand_ready = 1'b0;
    freeze_ack = 1'b1;
    beats_seen = 0;
    done_seen  = 0;
    dump_start = 1'b1;
    dump_mask  = 32'h0010_0402;
    tick();
    dump_start = 1'b0;
    tick();
    chk("read_idx", 64'(map_raddr), 64'(1));
    chk("read_prf_tag", 64'(prf_raddr), 64'(map_tbl[1]));
    tick();
    chk("wait_no_valid", 64'(ob.out_valid), 64'(0));
    reset = 1'b0;
    tick();
    chk("mid_rst_ctrl", 64'({dump_busy, dump_done, freeze_req, ob.out_valid}), 64'(0));
    chk("mid_rst_beat", 64'({ob.out_areg, ob.out_preg, ob.out_data, ob.out_last}), 64'(0));
    chk("mid_rst_raddr", 64'({map_raddr, prf_raddr}), 64'(0));
    reset = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", 64'(dump_busy), 64'(0));
    chk("post_rst_no_done", 64'(done_seen), 64'(0));
    chk("post_rst_no_beats", 64'(beats_seen), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
